imm_encoder: RTL and testbench

- Inverse of the immediate-extraction path: packs opcode, register fields, funct fields and a 32-bit signed immediate into one RV32I instruction word.
- Sits in the program-generation / boot-ROM loader path, in front of instruction memory.
- Range-checks the immediate against the target format and queues encoded words in a small FIFO.
- Valid/ready handshake on both sides.

---
 rtl/imm_encoder.sv | 161 ++++++++++++++++
 tb/tb_imm_encoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : imm_encoder                                                   |
// | Purpose  : Packs RV32I fields into one instruction word, range-checks the |
// |            immediate and queues results in a small FWFT FIFO.            |
// |            Optional macro IMM_ENCODER_ERRCNT_EN adds a saturating error   |
// |            counter output (err_cnt_o).                                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module imm_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [6:0]       opcode_i,
    input  logic [4:0]       rd_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic [2:0]       funct3_i,
    input  logic [6:0]       funct7_i,
    input  logic [31:0]      imm_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [31:0]      instr_o,
    output logic             err_o,
`ifdef IMM_ENCODER_ERRCNT_EN
    output logic [CNT_W-1:0] err_cnt_o,
`endif
    output logic [CNT_W-1:0] cnt_o
);

    localparam int              c_addr_w = $clog2(DEPTH);
    localparam logic [c_addr_w:0] c_full = (c_addr_w + 1)'(DEPTH);
    localparam logic [6:0]      c_op_i   = 7'b0010011;
    localparam logic [6:0]      c_op_r   = 7'b0110011;
    localparam logic [6:0]      c_op_s   = 7'b0100011;
    localparam logic [6:0]      c_op_b   = 7'b1100011;
    localparam logic [6:0]      c_op_l   = 7'b0000011;
    localparam logic [31:0]     c_nop    = 32'h0000_0013;

    logic [31:0]         w_word;
    logic                w_err;
    logic                w_imm12_ok;
    logic                w_imm13_ok;
    logic                w_push;
    logic                w_pop;
    logic [c_addr_w-1:0] w_rd_ptr_nxt;
    logic [c_addr_w:0]   w_count_nxt;

    logic [32:0]         r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    logic                r_valid;
    logic [31:0]         r_instr;
    logic                r_err;
    logic [CNT_W-1:0]    r_cnt;

    // Sign-extension check: upper bits must all equal the format's sign bit.
    assign w_imm12_ok = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign w_imm13_ok = ((&imm_i[31:12]) | ~(|imm_i[31:12])) & ~imm_i[0];

    always_comb begin
        w_word = c_nop;
        w_err  = 1'b1;
        case (opcode_i)
            c_op_i, c_op_l: begin
                w_err  = ~w_imm12_ok;
                w_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            end
            c_op_r: begin
                w_err  = 1'b0;
                w_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            end
            c_op_s: begin
                w_err  = ~w_imm12_ok;
                w_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            end
            c_op_b: begin
                w_err  = ~w_imm13_ok;
                w_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                          imm_i[4:1], imm_i[11], opcode_i};
            end
            default: begin
                w_err  = 1'b1;
                w_word = c_nop;
            end
        endcase
        if (w_err) begin
            w_word = c_nop;
        end
    end

    assign ready_o      = (r_count != c_full);
    assign w_push       = valid_i && ready_o;
    assign w_pop        = r_valid && ready_i;
    assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
    assign w_count_nxt  = r_count + {{c_addr_w{1'b0}}, w_push}
                                  - {{c_addr_w{1'b0}}, w_pop};

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_err, w_word};
        end
    end

    // The head register looks ahead: when the new head is the slot being
    // written this cycle, it takes the freshly encoded word directly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_instr  <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_valid  <= (w_count_nxt != '0);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_cnt    <= r_cnt + 1'b1;
            end
            if (w_count_nxt != '0) begin
                if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
                    r_instr <= w_word;
                    r_err   <= w_err;
                end else begin
                    r_instr <= r_mem[w_rd_ptr_nxt][31:0];
                    r_err   <= r_mem[w_rd_ptr_nxt][32];
                end
            end
        end
    end

`ifdef IMM_ENCODER_ERRCNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_cnt <= '0;
        end else if (w_push && w_err && !(&r_err_cnt)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt_o = r_err_cnt;
`endif

    assign valid_o = r_valid;
    assign instr_o = r_instr;
    assign err_o   = r_err;
    assign cnt_o   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_imm_encoder                                                |
// | Purpose  : Directed self-checking bench for imm_encoder.                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_imm_encoder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [6:0]  opcode_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] imm_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic        err_o;
    logic [15:0] cnt_o;
`ifdef IMM_ENCODER_ERRCNT_EN
    logic [15:0] err_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    imm_encoder #(.DEPTH(4), .CNT_W(16)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .opcode_i (opcode_i),
        .rd_i     (rd_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .funct3_i (funct3_i),
        .funct7_i (funct7_i),
        .imm_i    (imm_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .instr_o  (instr_o),
        .err_o    (err_o),
`ifdef IMM_ENCODER_ERRCNT_EN
        .err_cnt_o(err_cnt_o),
`endif
        .cnt_o    (cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] imm);
        opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        funct3_i = f3; funct7_i = f7; imm_i = imm; valid_i = 1'b1;
    endtask

    // One accepted request, sampled 1 time unit after the accepting edge.
    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        set_req(op, rd, rs1, rs2, f3, f7, imm);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
    endtask

    function automatic logic [31:0] iword(input int imm);
        return (32'(imm) << 20) | 32'h0000_0093;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        set_req(7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_err",   32'(err_o), 32'd0);
        chk("rst_cnt",   32'(cnt_o), 32'd0);
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("rel_ready", 32'(ready_o), 32'd1);
        ready_i = 1'b1;

        // Valid formats
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        chk("i_valid", 32'(valid_o), 32'd1);
        chk("i_instr", instr_o, 32'h0050_0093);
        chk("i_err",   32'(err_o), 32'd0);
        chk("i_cnt",   32'(cnt_o), 32'd1);
        send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF);
        chk("r_instr", instr_o, 32'h0020_81B3);
        chk("r_err",   32'(err_o), 32'd0);
        send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
        chk("s_instr", instr_o, 32'h0020_A423);
        chk("s_err",   32'(err_o), 32'd0);
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4);
        chk("b_instr", instr_o, 32'hFE20_8EE3);
        chk("b_err",   32'(err_o), 32'd0);
        chk("b_cnt",   32'(cnt_o), 32'd4);

        // Error cases
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        chk("ei_instr", instr_o, 32'h0000_0013);
        chk("ei_err",   32'(err_o), 32'd1);
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        chk("eb_instr", instr_o, 32'h0000_0013);
        chk("eb_err",   32'(err_o), 32'd1);
        send(7'b1111111, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        chk("eo_instr", instr_o, 32'h0000_0013);
        chk("eo_err",   32'(err_o), 32'd1);
        chk("e_cnt",    32'(cnt_o), 32'd7);
`ifdef IMM_ENCODER_ERRCNT_EN
        chk("err_cnt",  32'(err_cnt_o), 32'd3);
`endif

        // Range boundaries that must pass
        send(7'b0000011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048);
        chk("lmin_instr", instr_o, 32'h8000_0083);
        chk("lmin_err",   32'(err_o), 32'd0);
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4094);
        chk("bmax_instr", instr_o, 32'h7E20_8FE3);
        chk("bmax_err",   32'(err_o), 32'd0);
        @(posedge clk_i); #1;
        chk("drain_valid", 32'(valid_o), 32'd0);
        chk("drain_hold",  instr_o, 32'h7E20_8FE3);

        // Backpressure: fill four, fifth stalls
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(10 + i));
        end
        set_req(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd14);
        chk("bp_ready_low", 32'(ready_o), 32'd0);
        @(posedge clk_i); #1;
        chk("bp_still_low", 32'(ready_o), 32'd0);
        chk("bp_head",      instr_o, iword(10));
        chk("bp_cnt",       32'(cnt_o), 32'd13);
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("bp_pop1", instr_o, iword(11));
        chk("bp_nobypass_cnt", 32'(cnt_o), 32'd13);
        chk("bp_ready_up", 32'(ready_o), 32'd1);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        chk("bp_pop2", instr_o, iword(12));
        chk("bp_cnt5", 32'(cnt_o), 32'd14);
        @(posedge clk_i); #1;
        chk("bp_pop3", instr_o, iword(13));
        @(posedge clk_i); #1;
        chk("bp_pop5", instr_o, iword(14));
        @(posedge clk_i); #1;
        chk("bp_empty", 32'(valid_o), 32'd0);

        // Steady push/pop at occupancy 2 across pointer wrap
        ready_i = 1'b0;
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd20);
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd21);
        ready_i = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            set_req(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(21 + k));
            @(posedge clk_i); #1;
            chk($sformatf("pp_head%0d", k), instr_o, iword(20 + k));
        end
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        chk("pp_tail", instr_o, iword(31));
        chk("pp_tail_valid", 32'(valid_o), 32'd1);
        @(posedge clk_i); #1;
        chk("pp_empty", 32'(valid_o), 32'd0);
        chk("pp_cnt", 32'(cnt_o), 32'd26);

        // Asynchronous reset with entries queued
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(40 + i));
        end
        chk("pre_rst_valid", 32'(valid_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_valid", 32'(valid_o), 32'd0);
        chk("arst_cnt",   32'(cnt_o), 32'd0);
`ifdef IMM_ENCODER_ERRCNT_EN
        chk("arst_errcnt", 32'(err_cnt_o), 32'd0);
`endif
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("arst_ready", 32'(ready_o), 32'd1);
        chk("arst_empty", 32'(valid_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
